// File: rtl/core_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// core_writeback_arbiter : routes ALU A to write port A, and ALU B plus three
// buffered single-issue units (mul, ldst, branch) to write port B.
// Revision 1.0
// ============================================================================

module core_writeback_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_a_valid,
  input  logic [3:0]  alu_a_rd,
  input  logic [31:0] alu_a_value,
  input  logic        alu_b_valid,
  input  logic [3:0]  alu_b_rd,
  input  logic [31:0] alu_b_value,
  input  logic        mul_valid,
  input  logic [3:0]  mul_rd,
  input  logic [31:0] mul_value,
  input  logic        ldst_valid,
  input  logic [3:0]  ldst_rd,
  input  logic [31:0] ldst_value,
  input  logic        branch_valid,
  input  logic [3:0]  branch_rd,
  input  logic [31:0] branch_value,
  output logic        wb_stall_mul,
  output logic        wb_stall_ldst,
  output logic        wb_stall_branch,
  output logic        wr_en_a,
  output logic [3:0]  wr_r_a,
  output logic [31:0] wr_value_a,
  output logic        wr_en_b,
  output logic [3:0]  wr_r_b,
  output logic [31:0] wr_value_b,
  output logic [15:0] wb_pending
);

  localparam int         c_num_units  = 3;
  localparam logic [1:0] c_ptr_mul    = 2'd0;
  localparam logic [1:0] c_ptr_ldst   = 2'd1;
  localparam logic [1:0] c_ptr_branch = 2'd2;

  // Unit index 0 = mul, 1 = ldst, 2 = branch throughout.
  logic [2:0]  w_unit_valid;
  logic [3:0]  w_unit_rd    [c_num_units];
  logic [31:0] w_unit_value [c_num_units];

  logic [2:0]  r_buf_valid;
  logic [3:0]  r_buf_rd     [c_num_units];
  logic [31:0] r_buf_value  [c_num_units];
  logic [1:0]  r_rr_ptr;

  logic [2:0]  w_grant;
  logic [2:0]  w_stall;
  logic [3:0]  w_grant_rd;
  logic [31:0] w_grant_value;

  assign w_unit_valid    = {branch_valid, ldst_valid, mul_valid};
  assign w_unit_rd[0]    = mul_rd;
  assign w_unit_rd[1]    = ldst_rd;
  assign w_unit_rd[2]    = branch_rd;
  assign w_unit_value[0] = mul_value;
  assign w_unit_value[1] = ldst_value;
  assign w_unit_value[2] = branch_value;

  // ALU B owns port B outright; buffers only compete when it is idle.
  always_comb begin
    w_grant = 3'b000;
    if (!alu_b_valid) begin
      case (r_rr_ptr)
        c_ptr_mul: begin
          if      (r_buf_valid[0]) w_grant = 3'b001;
          else if (r_buf_valid[1]) w_grant = 3'b010;
          else if (r_buf_valid[2]) w_grant = 3'b100;
        end
        c_ptr_ldst: begin
          if      (r_buf_valid[1]) w_grant = 3'b010;
          else if (r_buf_valid[2]) w_grant = 3'b100;
          else if (r_buf_valid[0]) w_grant = 3'b001;
        end
        default: begin
          if      (r_buf_valid[2]) w_grant = 3'b100;
          else if (r_buf_valid[0]) w_grant = 3'b001;
          else if (r_buf_valid[1]) w_grant = 3'b010;
        end
      endcase
    end
  end

  always_comb begin
    w_grant_rd    = r_buf_rd[2];
    w_grant_value = r_buf_value[2];
    if (w_grant[0]) begin
      w_grant_rd    = r_buf_rd[0];
      w_grant_value = r_buf_value[0];
    end else if (w_grant[1]) begin
      w_grant_rd    = r_buf_rd[1];
      w_grant_value = r_buf_value[1];
    end
  end

  assign w_stall         = r_buf_valid & ~w_grant;
  assign wb_stall_mul    = w_stall[0];
  assign wb_stall_ldst   = w_stall[1];
  assign wb_stall_branch = w_stall[2];

  always_comb begin
    wb_pending = 16'h0000;
    for (int i = 0; i < c_num_units; i++) begin
      if (r_buf_valid[i]) wb_pending = wb_pending | (16'h0001 << r_buf_rd[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_a    <= 1'b0;
      wr_r_a     <= 4'd0;
      wr_value_a <= 32'd0;
    end else begin
      wr_en_a    <= alu_a_valid;
      wr_r_a     <= alu_a_rd;
      wr_value_a <= alu_a_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_b    <= 1'b0;
      wr_r_b     <= 4'd0;
      wr_value_b <= 32'd0;
      r_rr_ptr   <= c_ptr_mul;
    end else if (alu_b_valid) begin
      wr_en_b    <= 1'b1;
      wr_r_b     <= alu_b_rd;
      wr_value_b <= alu_b_value;
    end else if (|w_grant) begin
      wr_en_b    <= 1'b1;
      wr_r_b     <= w_grant_rd;
      wr_value_b <= w_grant_value;
      r_rr_ptr   <= w_grant[0] ? c_ptr_ldst :
                    w_grant[1] ? c_ptr_branch : c_ptr_mul;
    end else begin
      wr_en_b    <= 1'b0;
    end
  end

  // A pulse while stalled matches neither branch, so the result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 3'b000;
      for (int i = 0; i < c_num_units; i++) begin
        r_buf_rd[i]    <= 4'd0;
        r_buf_value[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < c_num_units; i++) begin
        if (w_unit_valid[i] && (!r_buf_valid[i] || w_grant[i])) begin
          r_buf_valid[i] <= 1'b1;
          r_buf_rd[i]    <= w_unit_rd[i];
          r_buf_value[i] <= w_unit_value[i];
        end else if (w_grant[i]) begin
          r_buf_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  for (genvar gi = 0; gi < c_num_units; gi++) begin : g_protocol_chk
    a_no_valid_while_stalled: assert property (
      @(posedge clk) disable iff (!rst_n) !(w_unit_valid[gi] && w_stall[gi]));
  end
`endif

endmodule

`default_nettype wire

// File: doc/core_writeback_arbiter.md
# core_writeback_arbiter

Shares the register file's two write ports among the five execution units that leave dispatch: ALU A, ALU B, multiplier, load/store and branch (link writes). Port A is owned by ALU A; port B is shared. ALU B has fixed priority on port B, and the three single-issue units drain through one-entry holding buffers under round-robin arbitration. The block drives per-unit writeback stalls (including `wb_stall_branch` consumed by dispatch) and a pending-register mask for hazard detection.

## Interface
- No parameters. `word` is 32 bits, `reg_num` is 4 bits and `hword` is 16 bits, all from `core/uarch.sv`.
- `clk`  in  1  core clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_a_valid`, `alu_b_valid`  in  1  ALU result present this cycle.
- `alu_a_rd`, `alu_b_rd`  in  reg_num  destination register.
- `alu_a_value`, `alu_b_value`  in  word  result.
- `mul_valid`, `ldst_valid`, `branch_valid`  in  1  single-issue unit result present; one-cycle pulse per result.
- `mul_rd`, `ldst_rd`, `branch_rd`  in  reg_num  destination register.
- `mul_value`, `ldst_value`, `branch_value`  in  word  result.
- `wb_stall_mul`, `wb_stall_ldst`, `wb_stall_branch`  out  1  unit must not pulse valid.
- `wr_en_a`, `wr_en_b`  out  1  register file write enables (registered).
- `wr_r_a`, `wr_r_b`  out  reg_num  write addresses (registered).
- `wr_value_a`, `wr_value_b`  out  word  write data (registered).
- `wb_pending`  out  hword  one-hot OR of the `rd` fields of all occupied holding buffers.

## Operation
- Port A: at each edge, `wr_en_a <= alu_a_valid`, `wr_r_a <= alu_a_rd` and `wr_value_a <= alu_a_value`. There is no arbitration on port A.
- Holding buffers: there is one per single-issue unit (mul, ldst, branch). Each holds a valid bit, `rd` and `value`.
  - A buffer captures its unit's result at the edge when `x_valid` is high and the buffer is empty or granted that cycle.
  - A unit result never writes port B directly.
- Port B source selection, each cycle:
  - If `alu_b_valid` is high, ALU B is loaded into the port B register and no buffer is granted.
  - Otherwise, if any buffer is valid, one buffer is granted by round-robin and loaded; it empties at that edge unless it recaptures.
  - Otherwise `wr_en_b <= 0`.
- Round-robin:
  - The priority order is mul → ldst → branch → mul.
  - The pointer names the highest-priority unit. After a grant it moves to the unit following the granted one.
  - The pointer does not move when nothing is granted or when ALU B blocks the port.
- Stalls are combinational: `wb_stall_x = buf_x.valid && !grant_x`.
- Protocol violation: `x_valid` asserted while `wb_stall_x` is high. The new result is dropped, the buffer is unchanged, and a simulation assertion fires.
- `wb_pending` is derived from buffer state only. It excludes in-flight port register contents.
- Ordering between same-`rd` writes is guaranteed by the dispatch hazard masks. The arbiter does not check address collisions between ports.
- Flush has no effect: every result reaching this block is committed.

## Timing
- Reset values:
  - `wr_en_a = 0`, `wr_en_b = 0`.
  - All buffers empty, so all stalls are 0 and `wb_pending = 0`.
  - The round-robin pointer points at mul.
  - `wr_r_*` and `wr_value_*` are 0.
- Reset asserted mid-operation discards all buffered results immediately (asynchronous).
- ALU A and ALU B: valid in cycle t → write port asserted in cycle t+1.
- Single-issue unit, uncontended: valid in cycle t → buffered at the end of t → granted in t+1 → `wr_en_b` in t+2. Minimum latency is 2 cycles.
- Sustained throughput: one buffered result per cycle on port B while ALU B is idle. A unit pulsing every cycle alone is never stalled, because capture and grant happen in the same cycle.
- Worst case with all three buffers full and ALU B idle: the last unit drains in 3 cycles.
- Continuous `alu_b_valid` starves the buffers. This is permitted; dispatch bounds it.

## Test plan
- Reset, then `alu_a_valid=1`, `rd=3`, `value=0xDEADBEEF` in cycle 1 → `wr_en_a=1`, `wr_r_a=3`, `wr_value_a=0xDEADBEEF` in cycle 2; `wr_en_b=0`.
- `mul_valid` with `rd=5` in cycle 1, ALU B idle:
  - `wb_pending=0x0020` in cycle 2.
  - `wr_en_b=1`, `wr_r_b=5` in cycle 3.
  - No stall in any cycle.
- `mul`, `ldst` and `branch` pulse together (`rd` 1, 2, 3) with the pointer at mul:
  - Port B writes `rd` 1, 2, 3 in cycles 3, 4, 5.
  - `wb_stall_branch` is high in cycles 2–3.
  - `wb_pending` goes 0x000E → 0x000C → 0x0008 → 0.
- `ldst` pulses with `rd=7` and `alu_b_valid` is held high for cycles 1–4:
  - Port B carries ALU B in cycles 2–5.
  - `ldst` writes in cycle 6.
  - `wb_stall_ldst` is high in cycles 2–4.
  - The pointer is unchanged until the grant.
- `mul` pulses every cycle for 4 cycles, alone → four consecutive port B writes in cycles 3–6, with `wb_stall_mul` never high.
- Fill all three buffers, then drop `rst_n` asynchronously mid-cycle → outputs clear immediately: `wr_en_b=0`, `wb_pending=0`, all stalls 0.
